// File: rtl/wb_stream_writer_if.sv
// rtl/wb_stream_writer_if.sv - stream input and Wishbone pipelined master bundle for wb_stream_writer
interface wb_stream_writer_if #(
    parameter int AW = 10,
    parameter int DW = 8
) ();
    logic          i_valid;
    logic [DW-1:0] i_data;
    logic          o_ready;
    logic          o_wb_cyc;
    logic          o_wb_stb;
    logic          o_wb_we;
    logic [AW-1:0] o_wb_addr;
    logic [DW-1:0] o_wb_data;
    logic          i_wb_stall;
    logic          i_wb_ack;
    logic          i_wb_err;

    modport master (
        input  i_valid, i_data, i_wb_stall, i_wb_ack, i_wb_err,
        output o_ready, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data
    );

    modport slave (
        output i_valid, i_data, i_wb_stall, i_wb_ack, i_wb_err,
        input  o_ready, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data
    );
endinterface

// File: rtl/wb_stream_writer.sv
// rtl/wb_stream_writer.sv - stream-to-Wishbone sequential writer; optional ack timeout via WBSW_TIMEOUT_EN
module wb_stream_writer #(
    parameter int AW      = 10,
    parameter int DW      = 8,
    parameter int MAX_OUT = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [AW-1:0]     i_base,
    input  logic [AW:0]       i_len,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    wb_stream_writer_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_BURST, S_DRAIN} state_t;

    localparam logic [AW-1:0] ADDR_ONE  = 1;
    localparam logic [AW:0]   LEN_ONE   = 1;
    localparam logic [4:0]    MAX_OUT_W = 5'(MAX_OUT);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   issued_q, issued_d;
    logic [3:0]    out_q, out_d;
    logic          stb_q, stb_d;
    logic [DW-1:0] data_q, data_d;
    logic          err_q, err_d;
    logic          done_q, done_d;

    logic          cyc;
    logic          req_acc;
    logic          ack_ok;
    logic          tmo_hit;
    logic          abort;
    logic [4:0]    inflight;
    logic          ready;
    logic          beat;

    assign cyc      = (state_q != S_IDLE);
    assign req_acc  = stb_q && !bus.i_wb_stall;
    assign ack_ok   = bus.i_wb_ack && (out_q != 4'd0);
    assign abort    = cyc && (bus.i_wb_err || tmo_hit);
    // A pending strobe is counted as in flight so the bus never holds more than MAX_OUT unacked requests.
    assign inflight = {1'b0, out_q} + {4'b0000, stb_q};
    assign ready    = (state_q == S_BURST) && (!stb_q || !bus.i_wb_stall) &&
                      (issued_q < len_q) && (inflight < MAX_OUT_W) && !abort;
    assign beat     = ready && bus.i_valid;

`ifdef WBSW_TIMEOUT_EN
    logic [7:0] tmo_q, tmo_d;

    // Ack watchdog: counts cycles with requests outstanding and no ack; the aborting edge is the one that would make it 255.
    always_comb begin
        tmo_d = tmo_q;
        if (!cyc || bus.i_wb_ack || (out_q == 4'd0)) begin
            tmo_d = 8'd0;
        end else begin
            tmo_d = tmo_q + 8'd1;
        end
    end

    assign tmo_hit = cyc && (out_q != 4'd0) && !bus.i_wb_ack && (tmo_q == 8'd254);

    // Watchdog register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            tmo_q <= 8'd0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Next-state logic: command intake, beat loading, request retirement, ack bookkeeping and abort.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        issued_d = issued_q;
        stb_d    = stb_q;
        data_d   = data_q;
        err_d    = err_q;
        done_d   = 1'b0;

        case ({req_acc, ack_ok})
            2'b10:   out_d = out_q + 4'd1;
            2'b01:   out_d = out_q - 4'd1;
            default: out_d = out_q;
        endcase

        if (req_acc) begin
            addr_d = addr_q + ADDR_ONE;
            stb_d  = 1'b0;
        end
        if (beat) begin
            stb_d    = 1'b1;
            data_d   = bus.i_data;
            issued_d = issued_q + LEN_ONE;
        end

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    err_d = 1'b0;
                    if (i_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d   = i_base;
                        len_d    = i_len;
                        issued_d = '0;
                        out_d    = 4'd0;
                        state_d  = S_BURST;
                    end
                end
            end
            S_BURST: begin
                // When the final ack lands in the same cycle the burst empties, finish without visiting DRAIN.
                if ((issued_q == len_q) && !stb_q) begin
                    if (out_d == 4'd0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (out_d == 4'd0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d = S_IDLE;
            stb_d   = 1'b0;
            out_d   = 4'd0;
            err_d   = 1'b1;
            done_d  = 1'b1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            issued_q <= '0;
            out_q    <= 4'd0;
            stb_q    <= 1'b0;
            data_q   <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            issued_q <= issued_d;
            out_q    <= out_d;
            stb_q    <= stb_d;
            data_q   <= data_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    assign o_busy        = cyc;
    assign o_done        = done_q;
    assign o_err         = err_q;
    assign bus.o_ready   = ready;
    assign bus.o_wb_cyc  = cyc;
    assign bus.o_wb_stb  = stb_q;
    assign bus.o_wb_we   = cyc;
    assign bus.o_wb_addr = addr_q;
    assign bus.o_wb_data = data_q;
endmodule

// File: tb/tb_wb_stream_writer.sv
// tb/tb_wb_stream_writer.sv - directed table-driven bench for wb_stream_writer
module tb_wb_stream_writer;
    localparam int AW      = 10;
    localparam int DW      = 8;
    localparam int MAX_OUT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base;
    logic [AW:0]   len;
    logic          busy, done, err;

    wb_stream_writer_if #(.AW(AW), .DW(DW)) bus ();

    wb_stream_writer #(.AW(AW), .DW(DW), .MAX_OUT(MAX_OUT)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_start (start),
        .i_base  (base),
        .i_len   (len),
        .o_busy  (busy),
        .o_done  (done),
        .o_err   (err),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [9:0]  base;
        logic [10:0] len;
        logic [7:0]  d0;
        int          stall_idx;
        int          stall_n;
        int          err_ack;
        logic        exp_err;
        int          exp_writes;
        int          exp_done_cyc;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        start          = 1'b0;
        bus.i_valid    = 1'b0;
        bus.i_data     = '0;
        bus.i_wb_stall = 1'b0;
        bus.i_wb_ack   = 1'b0;
        bus.i_wb_err   = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"},  err, 0);
        chk({tag, "_ready"}, bus.o_ready, 0);
        chk({tag, "_cyc"},  bus.o_wb_cyc, 0);
        chk({tag, "_stb"},  bus.o_wb_stb, 0);
        chk({tag, "_we"},   bus.o_wb_we, 0);
        chk({tag, "_addr"}, bus.o_wb_addr, 0);
        chk({tag, "_data"}, bus.o_wb_data, 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [9:0] wa[16];
        logic [7:0] wd[16];
        logic [9:0] h_addr;
        logic [7:0] h_data;
        logic       ack_pend;
        logic       cyc_seen;
        int nw, beats, acks, stall_cnt, err_cyc, done_cyc;
        nw = 0; beats = 0; acks = 0; stall_cnt = 0; err_cyc = -1; done_cyc = -1;
        ack_pend = 1'b0; cyc_seen = 1'b0; h_addr = '0; h_data = '0;

        @(negedge clk);
        start = 1'b1; base = v.base; len = v.len;
        for (int c = 1; c <= 80 && done_cyc < 0; c++) begin
            @(negedge clk);
            start        = 1'b0;
            bus.i_wb_ack = 1'b0;
            bus.i_wb_err = 1'b0;
            if (ack_pend) begin
                if (acks == v.err_ack) begin
                    bus.i_wb_err = 1'b1;
                    err_cyc = c;
                end else begin
                    bus.i_wb_ack = 1'b1;
                end
                acks++;
            end
            bus.i_wb_stall = bus.o_wb_stb && (nw == v.stall_idx) && (stall_cnt < v.stall_n);
            bus.i_valid    = (beats < int'(v.len));
            bus.i_data     = v.d0 + 8'(beats);
            #1;
            if (bus.o_wb_cyc) cyc_seen = 1'b1;
            if (bus.i_wb_stall) begin
                if (stall_cnt > 0) begin
                    chk($sformatf("v%0d_stall_addr_held", idx), bus.o_wb_addr, h_addr);
                    chk($sformatf("v%0d_stall_data_held", idx), bus.o_wb_data, h_data);
                end else begin
                    h_addr = bus.o_wb_addr;
                    h_data = bus.o_wb_data;
                end
                chk($sformatf("v%0d_stall_ready", idx), bus.o_ready, 0);
                stall_cnt++;
            end
            ack_pend = 1'b0;
            if (bus.o_wb_stb && !bus.i_wb_stall) begin
                if (nw < 16) begin
                    wa[nw] = bus.o_wb_addr;
                    wd[nw] = bus.o_wb_data;
                end
                nw++;
                ack_pend = 1'b1;
            end
            if (bus.i_valid && bus.o_ready) beats++;
            if (done) done_cyc = c;
        end

        chk($sformatf("v%0d_done_seen", idx), done_cyc >= 0, 1);
        chk($sformatf("v%0d_err", idx), err, v.exp_err);
        chk($sformatf("v%0d_cyc_at_done", idx), bus.o_wb_cyc, 0);
        chk($sformatf("v%0d_busy_at_done", idx), busy, 0);
        chk($sformatf("v%0d_cyc_seen", idx), cyc_seen, v.len != 0);
        if (v.exp_done_cyc >= 0)
            chk($sformatf("v%0d_done_cycle", idx), done_cyc, v.exp_done_cyc);
        if (v.err_ack >= 0)
            chk($sformatf("v%0d_done_after_err", idx), done_cyc, err_cyc + 1);
        if (v.exp_writes >= 0) begin
            chk($sformatf("v%0d_nwrites", idx), nw, v.exp_writes);
            for (int i = 0; i < v.exp_writes && i < nw && i < 16; i++) begin
                logic [9:0] ea;
                logic [7:0] ed;
                ea = v.base + 10'(i);
                ed = v.d0 + 8'(i);
                chk($sformatf("v%0d_waddr%0d", idx, i), wa[i], ea);
                chk($sformatf("v%0d_wdata%0d", idx, i), wd[i], ed);
            end
        end

        @(negedge clk);
        drive_idle();
        #1;
        chk($sformatf("v%0d_done_one_pulse", idx), done, 0);
        chk($sformatf("v%0d_cyc_after", idx), bus.o_wb_cyc, 0);
    endtask

    initial begin
        logic prev_err;
        int   beats, reqs, done_cnt;

        vecs[0] = '{10'h010, 11'd4, 8'hA1, -1, 0, -1, 1'b0,  4,  7};
        vecs[1] = '{10'h3FE, 11'd4, 8'hB1, -1, 0, -1, 1'b0,  4,  7};
        vecs[2] = '{10'h100, 11'd4, 8'hC1,  1, 3, -1, 1'b0,  4, -1};
        vecs[3] = '{10'h200, 11'd6, 8'hD1, -1, 0,  1, 1'b1, -1, -1};
        vecs[4] = '{10'h055, 11'd1, 8'hE1, -1, 0, -1, 1'b0,  1,  4};
        vecs[5] = '{10'h077, 11'd0, 8'h00, -1, 0, -1, 1'b0,  0,  1};

        drive_idle();
        base = '0;
        len  = '0;
        rst  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        prev_err = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("v%0d_err_before", k), err, prev_err);
            run_vec(vecs[k], k);
            prev_err = vecs[k].exp_err;
        end

        // Ack withheld: in-flight limit, resume after one ack, then reset mid-burst.
        @(negedge clk);
        start = 1'b1; base = 10'h020; len = 11'd8;
        beats = 0; reqs = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start = 1'b0; bus.i_valid = 1'b1; bus.i_data = 8'(c);
            #1;
            if (bus.o_wb_stb) reqs++;
            if (bus.o_ready) beats++;
        end
        chk("maxout_beats", beats, 4);
        chk("maxout_reqs", reqs, 4);
        chk("maxout_ready_low", bus.o_ready, 0);
        chk("maxout_busy", busy, 1);
        @(negedge clk);
        bus.i_wb_ack = 1'b1;
        #1;
        chk("maxout_ready_ack_cycle", bus.o_ready, 0);
        @(negedge clk);
        bus.i_wb_ack = 1'b0;
        #1;
        chk("maxout_ready_resumed", bus.o_ready, 1);

`ifndef WBSW_TIMEOUT_EN
        done_cnt = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            #1;
            if (done) done_cnt++;
        end
        chk("noto_busy", busy, 1);
        chk("noto_err", err, 0);
        chk("noto_done", done_cnt, 0);
`endif

        @(negedge clk);
        rst = 1'b1;
        bus.i_valid = 1'b0;
        @(negedge clk);
        #1;
        check_all_zero("midreset");
        rst = 1'b0;

`ifdef WBSW_TIMEOUT_EN
        begin
            int acc_cyc, err_cyc;
            acc_cyc = -1; err_cyc = -1;
            @(negedge clk);
            start = 1'b1; base = 10'h030; len = 11'd1;
            for (int c = 1; c <= 400 && err_cyc < 0; c++) begin
                @(negedge clk);
                start = 1'b0; bus.i_valid = 1'b1; bus.i_data = 8'h5A;
                #1;
                if (bus.o_wb_stb && acc_cyc < 0) acc_cyc = c;
                if (err) err_cyc = c;
            end
            chk("tmo_seen", err_cyc >= 0, 1);
            chk("tmo_delay", err_cyc - acc_cyc, 256);
            chk("tmo_done", done, 1);
            chk("tmo_cyc", bus.o_wb_cyc, 0);
            drive_idle();
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
